// File: rtl/rgb_mixer_pkg.sv
// Shared types and helpers for the RGB mixer: quadrature decode and duty stepping.
package rgb_mixer_pkg;

  localparam int unsigned MAX_W = 16;
  localparam int unsigned SUM_W = MAX_W + 1;

  // Clockwise Gray sequence on {A,B}: A leads B
  localparam logic [1:0] CW_S0 = 2'b00;
  localparam logic [1:0] CW_S1 = 2'b10;
  localparam logic [1:0] CW_S2 = 2'b11;
  localparam logic [1:0] CW_S3 = 2'b01;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CW,
    DIR_CCW
  } quad_dir_t;

  typedef struct packed {
    quad_dir_t dir;
    logic      illegal;
  } quad_res_t;

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      CW_S0:   return CW_S1;
      CW_S1:   return CW_S2;
      CW_S2:   return CW_S3;
      default: return CW_S0;
    endcase
  endfunction

  function automatic quad_res_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    quad_res_t r;
    r.dir     = DIR_NONE;
    r.illegal = 1'b0;
    if (cur != prev) begin
      if (cur == cw_next(prev))      r.dir = DIR_CW;
      else if (prev == cw_next(cur)) r.dir = DIR_CCW;
      else                           r.illegal = 1'b1;
    end
    return r;
  endfunction

  // Step a width-bit value up/down; borrow/carry land in the extra top bit
  function automatic logic [MAX_W-1:0] sat_step(input logic [MAX_W-1:0] value,
                                                input logic [MAX_W-1:0] step,
                                                input logic up,
                                                input logic saturate,
                                                input int unsigned width);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] maxv;
    logic [SUM_W-1:0] res;
    maxv = SUM_W'((32'd1 << width) - 32'd1);
    if (up) sum = {1'b0, value} + {1'b0, step};
    else    sum = {1'b0, value} - {1'b0, step};
    if (saturate) begin
      if (up) res = (sum > maxv) ? maxv : sum;
      else    res = sum[SUM_W-1] ? '0 : sum;
    end else begin
      res = sum & maxv;
    end
    return res[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rgb_mixer_pwm_ctrl_quad_decoder.sv
// Encoder front end: synchroniser, glitch filter, Gray decode and detent accumulator.
module quad_decoder
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned DETENT   = 4,
  parameter int unsigned FILT_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  output logic inc_o,
  output logic dec_o,
  output logic err_o
);

  localparam logic signed [4:0] ACC_MAX = 5'(DETENT);

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      prev_q;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic signed [4:0] acc_q, acc_d;
  logic            inc_q, inc_d, dec_q, dec_d, err_q, err_d;
  quad_res_t       res;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == 4'(FILT_CYC - 1)) filt_d[i] = sync2_q[i];
        else                               fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end

    res   = quad_decode(prev_q, filt_q);
    acc_d = acc_q;
    inc_d = 1'b0;
    dec_d = 1'b0;
    err_d = res.illegal;
    // A reversal restarts the count at +/-1 rather than unwinding
    case (res.dir)
      DIR_CW: begin
        acc_d = (acc_q < 0) ? 5'sd1 : acc_q + 5'sd1;
        if (acc_d == ACC_MAX) begin
          inc_d = 1'b1;
          acc_d = '0;
        end
      end
      DIR_CCW: begin
        acc_d = (acc_q > 0) ? -5'sd1 : acc_q - 5'sd1;
        if (acc_d == -ACC_MAX) begin
          dec_d = 1'b1;
          acc_d = '0;
        end
      end
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      prev_q  <= filt_q;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign inc_o = inc_q;
  assign dec_o = dec_q;
  assign err_o = err_q;

endmodule

// File: rtl/rgb_mixer_pwm_ctrl.sv
// RGB mixer top: button filter, channel select, per-channel duty/shadow and PWM.
module rgb_mixer_pwm_ctrl
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DETENT   = 4,
  parameter int unsigned FILT_CYC = 2,
  parameter int unsigned SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    encoder_A,
  input  logic                    encoder_B,
  input  logic                    sel_btn,
  output logic [N_CH-1:0]         pwm_out,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic                    quad_err
);

  localparam int unsigned CH_W     = $clog2(N_CH);
  localparam int unsigned CNT_LAST = (1 << PWM_W) - 2;

  logic inc, dec;

  quad_decoder #(
    .DETENT  (DETENT),
    .FILT_CYC(FILT_CYC)
  ) u_quad (
    .clk  (clk),
    .rst  (rst),
    .a_i  (encoder_A),
    .b_i  (encoder_B),
    .inc_o(inc),
    .dec_o(dec),
    .err_o(quad_err)
  );

  logic                         btn_s1_q, btn_s2_q, btn_q, btn_d, btn_prev_q;
  logic [3:0]                   bcnt_q, bcnt_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [N_CH-1:0][PWM_W-1:0]   duty_q, duty_d, shadow_q, shadow_d;
  logic [PWM_W-1:0]             cnt_q, cnt_d;
  logic [N_CH-1:0]              pwm_q, pwm_d;

  always_comb begin
    btn_d  = btn_q;
    bcnt_d = '0;
    if (btn_s2_q != btn_q) begin
      if (bcnt_q == 4'(FILT_CYC - 1)) btn_d  = btn_s2_q;
      else                            bcnt_d = bcnt_q + 4'd1;
    end

    // Events use the pre-advance channel when a press lands in the same cycle
    ch_d = ch_q;
    if (btn_q && !btn_prev_q) ch_d = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);

    duty_d = duty_q;
    if (inc || dec)
      duty_d[ch_q] = PWM_W'(sat_step(MAX_W'(duty_q[ch_q]), MAX_W'(STEP), inc,
                                     1'(SATURATE), PWM_W));

    cnt_d    = (cnt_q == PWM_W'(CNT_LAST)) ? '0 : cnt_q + PWM_W'(1);
    shadow_d = (cnt_q == '0) ? duty_q : shadow_q;
    for (int i = 0; i < int'(N_CH); i++) pwm_d[i] = (cnt_q < shadow_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      bcnt_q     <= '0;
      ch_q       <= '0;
      duty_q     <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
    end else begin
      btn_s1_q   <= sel_btn;
      btn_s2_q   <= btn_s1_q;
      btn_q      <= btn_d;
      btn_prev_q <= btn_q;
      bcnt_q     <= bcnt_d;
      ch_q       <= ch_d;
      duty_q     <= duty_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign active_ch = ch_q;

endmodule

// File: tb/tb_rgb_mixer_pwm_ctrl.sv
// Directed bench: saturating and wrapping instances driven in lockstep, duty measured from pwm_out.
module tb_rgb_mixer_pwm_ctrl;

  logic       clk;
  logic       rst, enc_a, enc_b, btn;
  logic [2:0] pwm_s, pwm_w;
  logic [1:0] ch_s, ch_w;
  logic       err_s, err_w;

  int checks   = 0;
  int failures = 0;
  int errc_s   = 0;
  int errc_w   = 0;

  rgb_mixer_pwm_ctrl #(.N_CH(3), .PWM_W(8), .STEP(16), .DETENT(4), .FILT_CYC(2), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .encoder_A(enc_a), .encoder_B(enc_b), .sel_btn(btn),
    .pwm_out(pwm_s), .active_ch(ch_s), .quad_err(err_s));

  rgb_mixer_pwm_ctrl #(.N_CH(3), .PWM_W(8), .STEP(16), .DETENT(4), .FILT_CYC(2), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .encoder_A(enc_a), .encoder_B(enc_b), .sel_btn(btn),
    .pwm_out(pwm_w), .active_ch(ch_w), .quad_err(err_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with quad_err high, so a stretched pulse is visible too
  always @(negedge clk) begin
    if (err_s) errc_s <= errc_s + 1;
    if (err_w) errc_w <= errc_w + 1;
  end

  typedef struct {
    int detents;   // signed: +CW / -CCW detents on the current channel
    int presses;
    int meas_ch;
    int exp_s;
    int exp_w;
    int exp_ch;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    @(negedge clk);
    enc_a = v[1];
    enc_b = v[0];
    repeat (3) @(negedge clk);
  endtask

  task automatic detent(input bit cw);
    if (cw) begin
      set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
    end else begin
      set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
    end
  endtask

  task automatic press();
    @(negedge clk);
    btn = 1'b1;
    repeat (6) @(negedge clk);
    btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Let any pending shadow load settle, then count high cycles over one period
  task automatic measure(input int ch, output int hs, output int hw);
    repeat (260) @(negedge clk);
    hs = 0;
    hw = 0;
    repeat (255) begin
      @(negedge clk);
      hs += int'(pwm_s[ch]);
      hw += int'(pwm_w[ch]);
    end
  endtask

  initial begin
    int hs, hw, n, nz;

    vecs[0] = '{ 1, 0, 0,  16,  16, 0};
    vecs[1] = '{19, 0, 0, 255,  64, 0};
    vecs[2] = '{ 0, 1, 1,   0,   0, 1};
    vecs[3] = '{ 2, 0, 1,  32,  32, 1};
    vecs[4] = '{ 0, 1, 0, 255,  64, 2};
    vecs[5] = '{-1, 0, 2,   0, 240, 2};
    vecs[6] = '{ 0, 1, 1,  32,  32, 0};
    vecs[7] = '{-1, 0, 0, 239,  48, 0};
    vecs[8] = '{ 0, 0, 2,   0, 240, 0};

    rst   = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    btn   = 1'b0;
    repeat (4) @(negedge clk);
    check("reset pwm_s", int'(pwm_s), 0);
    check("reset pwm_w", int'(pwm_w), 0);
    check("reset active_ch", int'(ch_s), 0);
    check("reset quad_err", int'(err_s), 0);
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      n = vecs[v].detents;
      for (int d = 0; d < ((n < 0) ? -n : n); d++) detent(n > 0);
      for (int p = 0; p < vecs[v].presses; p++) press();
      measure(vecs[v].meas_ch, hs, hw);
      check($sformatf("v%0d duty_sat ch%0d", v, vecs[v].meas_ch), hs, vecs[v].exp_s);
      check($sformatf("v%0d duty_wrap ch%0d", v, vecs[v].meas_ch), hw, vecs[v].exp_w);
      check($sformatf("v%0d active_ch_sat", v), int'(ch_s), vecs[v].exp_ch);
      check($sformatf("v%0d active_ch_wrap", v), int'(ch_w), vecs[v].exp_ch);
    end
    check("no quad_err during legal rotation sat", errc_s, 0);
    check("no quad_err during legal rotation wrap", errc_w, 0);

    // One-cycle glitch on A, then an illegal 00->11 jump and a legal way back
    @(negedge clk);
    enc_a = 1'b1;
    @(negedge clk);
    enc_a = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch quad_err", errc_s, 0);
    set_ab(2'b11);
    set_ab(2'b10);
    set_ab(2'b00);
    repeat (10) @(negedge clk);
    check("illegal jump quad_err cycles sat", errc_s, 1);
    check("illegal jump quad_err cycles wrap", errc_w, 1);
    measure(0, hs, hw);
    check("glitch duty_sat ch0", hs, 239);
    check("glitch duty_wrap ch0", hw, 48);

    press();
    repeat (4) @(negedge clk);
    check("pre-reset active_ch", int'(ch_s), 1);

    // Reset in the middle of a detent
    set_ab(2'b10);
    set_ab(2'b11);
    set_ab(2'b01);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid reset pwm_s", int'(pwm_s), 0);
    check("mid reset pwm_w", int'(pwm_w), 0);
    check("mid reset active_ch", int'(ch_s), 0);
    check("mid reset quad_err", int'(err_s), 0);
    rst = 1'b1;
    nz = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm_s != 3'b000) nz++;
      if (pwm_w != 3'b000) nz++;
    end
    check("post reset pwm all low cycles", nz, 0);
    set_ab(2'b00);
    measure(0, hs, hw);
    check("post reset extra transition duty_sat ch0", hs, 0);
    check("post reset extra transition duty_wrap ch0", hw, 0);
    detent(1'b1);
    measure(0, hs, hw);
    check("post reset detent duty_sat ch0", hs, 16);
    check("post reset detent duty_wrap ch0", hw, 16);
    measure(1, hs, hw);
    check("post reset duty_sat ch1", hs, 0);
    check("post reset duty_wrap ch1", hw, 0);
    check("final active_ch", int'(ch_w), 0);
    check("final quad_err cycles", errc_s, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
